// File: rtl/dense_mac_sched_pkg.sv
// Shared types and arithmetic helpers for the dense-layer MAC sequencer.
// Holds the FSM encoding, accumulator sizing and the output shift/saturate step.
package dense_mac_sched_pkg;

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  localparam int SAT_W = 128;
  localparam int RES_W = 64;

  // Wide enough for bias plus N_IN full-precision products without overflow.
  function automatic int acc_width(input int width, input int n_in);
    return 2 * width + $clog2(n_in) + 1;
  endfunction

  function automatic logic signed [RES_W-1:0] sat_trunc(
    input logic signed [SAT_W-1:0] acc,
    input int                      width,
    input int                      nfrac,
    input logic                    relu
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] maxv;
    logic signed [SAT_W-1:0] minv;
    sh   = acc >>> nfrac;
    maxv = (128'sd1 <<< (width - 1)) - 128'sd1;
    minv = -(128'sd1 <<< (width - 1));
    if (sh > maxv)
      sh = maxv;
    else if (sh < minv)
      sh = minv;
    if (relu && (sh < 128'sd0))
      sh = 128'sd0;
    return sh[RES_W-1:0];
  endfunction

endpackage

// File: rtl/dense_mac_sched_mac_unit.sv
// Single shared multiply-accumulate for the layer sequencer.
// Accumulator can be loaded with a scaled bias, accumulate one product, or hold.
module mac_unit #(
  parameter int DATA_W = 24,
  parameter int ACC_W  = 54,
  parameter int NFRAC  = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
  // Bias is aligned to the product's binary point (2*NFRAC fractional bits).
  assign bias_ext = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias} <<< NFRAC;

  always_ff @(posedge clk) begin
    if (reset)
      acc <= '0;
    else if (load)
      acc <= bias_ext;
    else if (acc_en)
      acc <= acc + prod_ext;
  end

endmodule

// File: rtl/dense_mac_sched.sv
// Time-multiplexed fully connected layer: one input vector in, N_OUT neurons
// computed term by term through a single MAC, rounded/saturated result vector out.
module dense_mac_sched
  import dense_mac_sched_pkg::*;
#(
  parameter int N_IN  = 32,
  parameter int N_OUT = 5,
  parameter int WIDTH = 24,
  parameter int NFRAC = 12,
  parameter int RELU  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN*WIDTH-1:0]      in_data,
  output logic [$clog2(N_IN)-1:0]    w_idx_i,
  output logic [$clog2(N_OUT)-1:0]   w_idx_o,
  input  logic [WIDTH-1:0]           w_data,
  input  logic [WIDTH-1:0]           b_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT*WIDTH-1:0]     out_data
);

  localparam int IW    = $clog2(N_IN);
  localparam int OW    = $clog2(N_OUT);
  localparam int ACC_W = acc_width(WIDTH, N_IN);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

  state_t                  state;
  logic [IW-1:0]           i;
  logic [OW-1:0]           o;
  logic [OW-1:0]           widx_o;
  logic [WIDTH-1:0]        x [N_IN];
  logic signed [ACC_W-1:0] acc;
  logic [WIDTH-1:0]        res;
  logic                    load;
  logic                    acc_en;

  assign w_idx_i = i;
  assign w_idx_o = widx_o;

  // Bias reload happens on accept and on every non-final STORE, where the
  // weight column index already points at the next neuron.
  assign load   = ((state == IDLE) && in_valid) || ((state == STORE) && (o != O_LAST));
  assign acc_en = (state == MAC);
  assign res    = WIDTH'(sat_trunc(SAT_W'(acc), WIDTH, NFRAC, RELU != 0));

  mac_unit #(
    .DATA_W(WIDTH),
    .ACC_W (ACC_W),
    .NFRAC (NFRAC)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .acc_en(acc_en),
    .bias  (b_data),
    .a     (x[i]),
    .b     (w_data),
    .acc   (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      o         <= '0;
      widx_o    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_IN; k++)
              x[k] <= in_data[k*WIDTH +: WIDTH];
            i        <= '0;
            o        <= '0;
            widx_o   <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          if (i == I_LAST) begin
            widx_o <= (o == O_LAST) ? '0 : o + 1'b1;
            state  <= STORE;
          end else begin
            i <= i + 1'b1;
          end
        end
        STORE: begin
          out_data[o*WIDTH +: WIDTH] <= res;
          i <= '0;
          if (o == O_LAST) begin
            o         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            o     <= o + 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_mac_sched.sv
// Directed/randomized bench for dense_mac_sched with an arithmetic reference model.
module tb_dense_mac_sched;

  localparam int N_IN  = 32;
  localparam int N_OUT = 5;
  localparam int WIDTH = 24;
  localparam int NFRAC = 12;
  localparam int IW    = $clog2(N_IN);
  localparam int OW    = $clog2(N_OUT);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset, in_valid, out_ready;
  logic [N_IN*WIDTH-1:0]  in_data;
  logic                   in_ready, out_valid, in_ready_r, out_valid_r;
  logic [IW-1:0]          w_idx_i, w_idx_i_r;
  logic [OW-1:0]          w_idx_o, w_idx_o_r;
  logic [WIDTH-1:0]       w_data, b_data, w_data_r, b_data_r;
  logic [N_OUT*WIDTH-1:0] out_data, out_data_r;

  logic signed [WIDTH-1:0] wt [N_IN][N_OUT];
  logic signed [WIDTH-1:0] bias [N_OUT];
  logic signed [WIDTH-1:0] xv [N_IN];

  assign w_data   = wt[w_idx_i][w_idx_o];
  assign b_data   = bias[w_idx_o];
  assign w_data_r = wt[w_idx_i_r][w_idx_o_r];
  assign b_data_r = bias[w_idx_o_r];

  dense_mac_sched #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .NFRAC(NFRAC), .RELU(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_idx_i(w_idx_i), .w_idx_o(w_idx_o), .w_data(w_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  dense_mac_sched #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .NFRAC(NFRAC), .RELU(1)) dut_r (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .w_idx_i(w_idx_i_r), .w_idx_o(w_idx_o_r), .w_data(w_data_r), .b_data(b_data_r),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r));

  int pass_cnt = 0;
  int total    = 0;

  // Edge-stamped event log for the throughput scenario.
  int cyc = 0;
  int acc_q[$];
  int hs_q[$];
  int rdy_q[$];
  logic [N_OUT*WIDTH-1:0] hs_data_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && in_valid && in_ready) acc_q.push_back(cyc);
    if (!reset && out_valid && out_ready) begin
      hs_q.push_back(cyc);
      hs_data_q.push_back(out_data);
    end
    if (!reset && in_ready) rdy_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WIDTH-1:0] ref_out(input int o, input bit relu);
    longint s;
    longint maxv;
    longint minv;
    s = longint'(bias[o]) * (64'sd1 <<< NFRAC);
    for (int k = 0; k < N_IN; k++)
      s += longint'(xv[k]) * longint'(wt[k][o]);
    s    = s >>> NFRAC;
    maxv = (64'sd1 <<< (WIDTH - 1)) - 1;
    minv = -(64'sd1 <<< (WIDTH - 1));
    if (s > maxv) s = maxv;
    if (s < minv) s = minv;
    if (relu && s < 0) s = 0;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rnd_small();
    int v;
    v = int'($urandom_range(0, 32767)) - 16384;
    return v[WIDTH-1:0];
  endfunction

  task automatic scramble_in();
    for (int k = 0; k < N_IN; k++)
      in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // Offers xv, waits for acceptance, then counts edges until out_valid shows.
  task automatic send_vec(output int lat);
    int waited;
    lat = 400;
    @(negedge clk);
    for (int k = 0; k < N_IN; k++)
      in_data[k*WIDTH +: WIDTH] = xv[k];
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(waited), 64'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_in();
    lat = 1;
    while (lat < 400) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int o = 0; o < N_OUT; o++) begin
      chk($sformatf("%s_n%0d", tag, o), 64'(out_data[o*WIDTH +: WIDTH]), 64'(ref_out(o, 1'b0)));
      chk($sformatf("%s_relu_n%0d", tag, o), 64'(out_data_r[o*WIDTH +: WIDTH]), 64'(ref_out(o, 1'b1)));
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_and_check(input string tag, input bit chk_lat);
    int lat;
    send_vec(lat);
    if (chk_lat) chk({tag, "_latency"}, 64'(lat), 64'd166);
    check_outputs(tag);
    release_out(tag);
  endtask

  initial begin
    logic [N_OUT*WIDTH-1:0] snap;
    int bad, lat, win;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      xv[k] = '0;
      for (int o = 0; o < N_OUT; o++) wt[k][o] = rnd_small();
    end
    for (int o = 0; o < N_OUT; o++) bias[o] = rnd_small();
    wt[0][0] = -24'sd49;
    bias[0]  = -24'sd255;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data == '0), 64'd1);
    chk("rst_w_idx_i", 64'(w_idx_i), 64'd0);
    chk("rst_w_idx_o", 64'(w_idx_o), 64'd0);

    // Zero input: result is the bias.
    send_vec(lat);
    chk("zero_latency", 64'(lat), 64'd166);
    chk("zero_n0_const", 64'(out_data[WIDTH-1:0]), 64'h00FFFF01);
    check_outputs("zero");
    release_out("zero");

    // Unit input on x[0]: w[0][o] + b[o].
    xv[0] = 24'h001000;
    send_vec(lat);
    chk("unit_n0_const", 64'(out_data[WIDTH-1:0]), 64'h00FFFED0);
    check_outputs("unit");
    release_out("unit");

    // Random vectors, moderate then full-range inputs.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N_IN; k++)
        xv[k] = (r == 2) ? WIDTH'($urandom) : rnd_small();
      run_and_check($sformatf("rand%0d", r), 1'b1);
    end

    // Saturation with unit weights and zero bias.
    for (int k = 0; k < N_IN; k++)
      for (int o = 0; o < N_OUT; o++) wt[k][o] = 24'h001000;
    for (int o = 0; o < N_OUT; o++) bias[o] = '0;
    for (int k = 0; k < N_IN; k++) xv[k] = 24'h7FFFFF;
    send_vec(lat);
    chk("satp_n3_const", 64'(out_data[3*WIDTH +: WIDTH]), 64'h007FFFFF);
    check_outputs("satp");
    release_out("satp");
    for (int k = 0; k < N_IN; k++) xv[k] = 24'h800000;
    send_vec(lat);
    chk("satn_n1_const", 64'(out_data[WIDTH +: WIDTH]), 64'h00800000);
    chk("satn_relu_n1_const", 64'(out_data_r[WIDTH +: WIDTH]), 64'd0);
    check_outputs("satn");

    // Backpressure: hold DONE for 20 cycles.
    snap = out_data;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_data !== snap || in_ready !== 1'b0 || out_valid !== 1'b1 ||
          w_idx_i !== '0 || w_idx_o !== '0) bad++;
    end
    chk("bp_stable_cycles_bad", 64'(bad), 64'd0);
    release_out("bp");

    // Back-to-back with out_ready held high.
    for (int k = 0; k < N_IN; k++)
      for (int o = 0; o < N_OUT; o++) wt[k][o] = rnd_small();
    for (int o = 0; o < N_OUT; o++) bias[o] = rnd_small();
    for (int k = 0; k < N_IN; k++) xv[k] = rnd_small();
    @(negedge clk);
    for (int k = 0; k < N_IN; k++) in_data[k*WIDTH +: WIDTH] = xv[k];
    acc_q.delete(); hs_q.delete(); rdy_q.delete(); hs_data_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    win = 0;
    while (acc_q.size() < 2 && win < 600) begin
      @(negedge clk);
      win++;
    end
    in_valid = 1'b0;
    win = 0;
    while (hs_q.size() < 2 && win < 600) begin
      @(negedge clk);
      win++;
    end
    out_ready = 1'b0;
    if (acc_q.size() >= 2 && hs_q.size() >= 2) begin
      chk("b2b_out_latency", 64'(hs_q[0] - acc_q[0]), 64'd166);
      chk("b2b_second_accept", 64'(acc_q[1] - acc_q[0]), 64'd167);
      bad = 0;
      foreach (rdy_q[n])
        if (rdy_q[n] > acc_q[0] && rdy_q[n] <= acc_q[0] + 166) bad++;
      chk("b2b_ready_low_window", 64'(bad), 64'd0);
      for (int o = 0; o < N_OUT; o++) begin
        chk($sformatf("b2b_v0_n%0d", o), 64'(hs_data_q[0][o*WIDTH +: WIDTH]), 64'(ref_out(o, 1'b0)));
        chk($sformatf("b2b_v1_n%0d", o), 64'(hs_data_q[1][o*WIDTH +: WIDTH]), 64'(ref_out(o, 1'b0)));
      end
    end else begin
      chk("b2b_timeout_events", 64'(acc_q.size() + hs_q.size()), 64'd4);
    end

    // Reset in the middle of a MAC run.
    for (int k = 0; k < N_IN; k++) xv[k] = rnd_small();
    @(negedge clk);
    for (int k = 0; k < N_IN; k++) in_data[k*WIDTH +: WIDTH] = xv[k];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_out_data", 64'(out_data == '0), 64'd1);
    chk("mrst_w_idx", 64'({w_idx_i, w_idx_o}), 64'd0);
    run_and_check("after_rst", 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
